// File: rtl/cu_microsequencer.sv
// rtl/cu_microsequencer.sv - microcode sequencer: micro-PC, micro-ROM addressing, control word output
//
// Holds the micro-PC and drives the synchronous micro-ROM address. It presents the
// active 59-bit control word to the field decoder. Each step follows the word's
// advance field [29:28]: 00 increment, 01 opcode dispatch, 10 return to fetch,
// 11 continue if cond_true, otherwise fetch. While a data-bus access is
// outstanding, the micro-PC holds and the same word stays active.
//
// Optional feature, macro CU_IRQ_DISPATCH_EN: a return to fetch is redirected to
// IRQ_ADDR when irq_pending & ime. irq_ack then pulses for one cycle.
//
// Ports:
//   clk             in   system clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   opcode          in   instruction buffer contents (dispatch target low byte)
//   cb_prefix       in   current opcode is CB-prefixed (dispatch target bit 8)
//   cond_true       in   branch condition for advance code 11
//   mem_ready       in   data-bus transfer completes this cycle
//   urom_data       in   micro-ROM read data, one cycle after uaddr
//   uaddr           out  micro-ROM address (combinational next address)
//   control_signals out  active control word (NOP_WORD until valid)
//   stall           out  sequencer holding for the bus
//   bus_timeout     out  sticky bus-wait timeout flag
//   irq_pending     in   interrupt request (optional feature)
//   ime             in   interrupt master enable (optional feature)
//   irq_ack         out  one-cycle interrupt accept pulse (optional feature, else 0)

module cu_microsequencer #(
   parameter int                  UADDR_W    = 10,
   parameter int                  CS_W       = 59,
   parameter logic [UADDR_W-1:0]  FETCH_ADDR = 'h200,
   parameter logic [UADDR_W-1:0]  IRQ_ADDR   = 'h210,
   parameter logic [CS_W-1:0]     NOP_WORD   = 'h0_4000_0004,
   parameter logic [7:0]          MAX_WAIT   = 8'd64
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [7:0]         opcode,
   input  logic               cb_prefix,
   input  logic               cond_true,
   input  logic               mem_ready,
   input  logic [CS_W-1:0]    urom_data,
   output logic [UADDR_W-1:0] uaddr,
   output logic [CS_W-1:0]    control_signals,
   output logic               stall,
   output logic               bus_timeout,
   input  logic               irq_pending,
   input  logic               ime,
   output logic               irq_ack
);

   logic [UADDR_W-1:0] upc;
   logic               valid;
   logic [7:0]         wait_cnt;
   logic [1:0]         adv;
   logic               mem_word;
   logic               hold;
   logic [UADDR_W-1:0] upc_inc;
   logic [UADDR_W-1:0] fetch_target;
   logic [UADDR_W-1:0] next_addr;

   assign control_signals = valid ? urom_data : NOP_WORD;
   assign adv             = control_signals[29:28];
   // db_nread (bit 30) or db_nwrite (bit 2) low marks a bus access word
   assign mem_word        = ~control_signals[30] | ~control_signals[2];
   assign hold            = valid & mem_word & ~mem_ready;
   assign stall           = hold;

   always_comb begin
      upc_inc      = upc + UADDR_W'(1);
      fetch_target = FETCH_ADDR;
`ifdef CU_IRQ_DISPATCH_EN
      if (irq_pending & ime)
         fetch_target = IRQ_ADDR;
`endif
      unique case (adv)
         2'b00:   next_addr = upc_inc;
         2'b01:   next_addr = UADDR_W'({cb_prefix, opcode});
         2'b10:   next_addr = fetch_target;
         default: next_addr = cond_true ? upc_inc : fetch_target;
      endcase
   end

   // Holding re-addresses upc so the ROM keeps returning the same word
   assign uaddr = (~valid | hold) ? upc : next_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         upc         <= FETCH_ADDR;
         valid       <= 1'b0;
         wait_cnt    <= 8'd0;
         bus_timeout <= 1'b0;
      end else begin
         upc   <= uaddr;
         valid <= 1'b1;
         if (hold) begin
            if (wait_cnt != 8'hFF)
               wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt == MAX_WAIT - 8'd1)
               bus_timeout <= 1'b1;
         end else begin
            wait_cnt <= 8'd0;
         end
      end
   end

`ifdef CU_IRQ_DISPATCH_EN
   logic irq_take;
   assign irq_take = valid & ~hold & irq_pending & ime &
                     ((adv == 2'b10) | ((adv == 2'b11) & ~cond_true));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         irq_ack <= 1'b0;
      else
         irq_ack <= irq_take;
   end
`else
   logic unused_irq_in;
   assign unused_irq_in = irq_pending ^ ime;
   assign irq_ack       = 1'b0;
`endif

endmodule

// File: tb/tb_cu_microsequencer.sv
// tb/tb_cu_microsequencer.sv - scoreboard bench for cu_microsequencer
module tb_cu_microsequencer;

   localparam logic [58:0] NOP = 59'h0_4000_0004;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  opcode = 8'h00;
   logic        cb_prefix = 1'b0;
   logic        cond_true = 1'b0;
   logic        mem_ready = 1'b1;
   logic [58:0] urom_data;
   logic [9:0]  uaddr;
   logic [58:0] control_signals;
   logic        stall;
   logic        bus_timeout;
   logic        irq_pending = 1'b0;
   logic        ime = 1'b0;
   logic        irq_ack;

   cu_microsequencer dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .opcode          (opcode),
      .cb_prefix       (cb_prefix),
      .cond_true       (cond_true),
      .mem_ready       (mem_ready),
      .urom_data       (urom_data),
      .uaddr           (uaddr),
      .control_signals (control_signals),
      .stall           (stall),
      .bus_timeout     (bus_timeout),
      .irq_pending     (irq_pending),
      .ime             (ime),
      .irq_ack         (irq_ack)
   );

   always #5 clk = ~clk;

   logic [58:0] rom [0:1023];
   always @(posedge clk) urom_data <= rom[uaddr];

   typedef struct {
      string      nm;
      int         act;
      logic [9:0] ua;
      logic       st;
      logic       to;
      logic       ack;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail = 0;

   function automatic logic [58:0] mkw(input int a, input logic [1:0] adv,
                                       input logic rd, input logic wr);
      logic [58:0] w;
      w         = NOP;
      w[58:49]  = 10'(a);
      w[20:10]  = 11'(a) ^ 11'h5A5;
      w[29:28]  = adv;
      if (rd) w[30] = 1'b0;
      if (wr) w[2]  = 1'b0;
      return w;
   endfunction

   task automatic chk(input string nm, input string fld, input logic [63:0] got,
                      input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s.%s: got %h expected %h", nm, fld, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() != 0) begin
         mon_e = q.pop_front();
         chk(mon_e.nm, "uaddr", 64'(uaddr), 64'(mon_e.ua));
         chk(mon_e.nm, "stall", 64'(stall), 64'(mon_e.st));
         chk(mon_e.nm, "cs", 64'(control_signals),
             64'((mon_e.act < 0) ? NOP : rom[mon_e.act]));
         chk(mon_e.nm, "timeout", 64'(bus_timeout), 64'(mon_e.to));
         chk(mon_e.nm, "irq_ack", 64'(irq_ack), 64'(mon_e.ack));
      end
   end

   task automatic step(input string nm, input logic rs, input logic [7:0] op,
                       input logic cb, input logic ct, input logic mr,
                       input logic ip, input logic ie, input int act,
                       input logic [9:0] ua, input logic st, input logic to,
                       input logic ack);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n       = rs;
      opcode      = op;
      cb_prefix   = cb;
      cond_true   = ct;
      mem_ready   = mr;
      irq_pending = ip;
      ime         = ie;
      e.nm = nm; e.act = act; e.ua = ua; e.st = st; e.to = to; e.ack = ack;
      q.push_back(e);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) rom[i] = mkw(i, 2'b00, 1'b0, 1'b0);
      rom['h200] = mkw('h200, 2'b00, 1'b0, 1'b0);
      rom['h203] = mkw('h203, 2'b01, 1'b0, 1'b0);
      rom['h03E] = mkw('h03E, 2'b10, 1'b0, 1'b0);
      rom['h137] = mkw('h137, 2'b00, 1'b1, 1'b0);
      rom['h138] = mkw('h138, 2'b01, 1'b0, 1'b0);
      rom['h150] = mkw('h150, 2'b11, 1'b0, 1'b0);
      rom['h151] = mkw('h151, 2'b01, 1'b0, 1'b0);
      rom['h060] = mkw('h060, 2'b10, 1'b0, 1'b1);
      rom['h210] = mkw('h210, 2'b10, 1'b0, 1'b0);

      for (int i = 0; i < 3; i++)
         step("reset", 0, 8'h00, 0, 0, 1, 0, 0, -1, 10'h200, 0, 0, 0);
      step("release", 1, 8'h00, 0, 0, 1, 0, 0, -1, 10'h200, 0, 0, 0);
      step("inc0",    1, 8'h00, 0, 0, 1, 0, 0, 'h200, 10'h201, 0, 0, 0);
      step("inc1",    1, 8'h00, 0, 0, 1, 0, 0, 'h201, 10'h202, 0, 0, 0);
      step("inc2",    1, 8'h00, 0, 0, 1, 0, 0, 'h202, 10'h203, 0, 0, 0);
      step("disp3e",  1, 8'h3E, 0, 0, 1, 0, 0, 'h203, 10'h03E, 0, 0, 0);
      step("ret",     1, 8'h00, 0, 0, 1, 0, 0, 'h03E, 10'h200, 0, 0, 0);
      step("inc0b",   1, 8'h00, 0, 0, 1, 0, 0, 'h200, 10'h201, 0, 0, 0);
      step("inc1b",   1, 8'h00, 0, 0, 1, 0, 0, 'h201, 10'h202, 0, 0, 0);
      step("inc2b",   1, 8'h00, 0, 0, 1, 0, 0, 'h202, 10'h203, 0, 0, 0);
      step("disp137", 1, 8'h37, 1, 0, 1, 0, 0, 'h203, 10'h137, 0, 0, 0);
      for (int i = 0; i < 3; i++)
         step("wait",  1, 8'h00, 0, 0, 0, 0, 0, 'h137, 10'h137, 1, 0, 0);
      step("wait_done", 1, 8'h00, 0, 0, 1, 0, 0, 'h137, 10'h138, 0, 0, 0);
      step("disp150", 1, 8'h50, 1, 0, 1, 0, 0, 'h138, 10'h150, 0, 0, 0);
      step("cond_t",  1, 8'h00, 0, 1, 1, 0, 0, 'h150, 10'h151, 0, 0, 0);
      step("disp150b",1, 8'h50, 1, 0, 1, 0, 0, 'h151, 10'h150, 0, 0, 0);
      step("cond_f",  1, 8'h00, 0, 0, 1, 0, 0, 'h150, 10'h200, 0, 0, 0);
      step("inc0c",   1, 8'h00, 0, 0, 1, 0, 0, 'h200, 10'h201, 0, 0, 0);
      step("inc1c",   1, 8'h00, 0, 0, 1, 0, 0, 'h201, 10'h202, 0, 0, 0);
      step("inc2c",   1, 8'h00, 0, 0, 1, 0, 0, 'h202, 10'h203, 0, 0, 0);
      step("disp060", 1, 8'h60, 0, 0, 1, 0, 0, 'h203, 10'h060, 0, 0, 0);
      // 64 hold cycles set the flag, visible from the 65th
      for (int h = 1; h <= 69; h++)
         step("long_wait", 1, 8'h00, 0, 0, 0, 1, 0, 'h060, 10'h060, 1, (h >= 65), 0);
      step("to_release", 1, 8'h00, 0, 0, 1, 1, 0, 'h060, 10'h200, 0, 1, 0);
      step("ime0_noack", 1, 8'h00, 0, 0, 1, 0, 0, 'h200, 10'h201, 0, 1, 0);
      step("inc1d",   1, 8'h00, 0, 0, 1, 0, 0, 'h201, 10'h202, 0, 1, 0);
      step("inc2d",   1, 8'h00, 0, 0, 1, 0, 0, 'h202, 10'h203, 0, 1, 0);
      step("disp3e_b",1, 8'h3E, 0, 0, 1, 0, 0, 'h203, 10'h03E, 0, 1, 0);
`ifdef CU_IRQ_DISPATCH_EN
      step("irq",     1, 8'h00, 0, 0, 1, 1, 1, 'h03E, 10'h210, 0, 1, 0);
      step("irq_ack", 1, 8'h00, 0, 0, 1, 0, 0, 'h210, 10'h200, 0, 1, 1);
`else
      step("irq",     1, 8'h00, 0, 0, 1, 1, 1, 'h03E, 10'h200, 0, 1, 0);
      step("irq_ack", 1, 8'h00, 0, 0, 1, 0, 0, 'h200, 10'h201, 0, 1, 0);
`endif
      step("mid_reset", 0, 8'h00, 0, 0, 1, 0, 0, -1, 10'h200, 0, 0, 0);
      step("mid_reset", 0, 8'h00, 0, 0, 1, 0, 0, -1, 10'h200, 0, 0, 0);
      step("release2",  1, 8'h00, 0, 0, 1, 0, 0, -1, 10'h200, 0, 0, 0);
      step("post_rst0", 1, 8'h00, 0, 0, 1, 0, 0, 'h200, 10'h201, 0, 0, 0);
      step("post_rst1", 1, 8'h00, 0, 0, 1, 0, 0, 'h201, 10'h202, 0, 0, 0);

      for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
